// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 12;
    localparam int SRAM_DATA_W = 16;

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } arb_state_t;

    localparam req_id_t REQ_ENGINE = 1'b0;
    localparam req_id_t REQ_HOST   = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag pipeline: shifts {valid,id} of each issued read so the
// return strobe lines up with the SRAM read data.
module rd_tag_pipe
    import sram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    reset_b,
    input  logic    push,
    input  req_id_t push_id,
    output logic    ret_valid,
    output req_id_t ret_id,
    output logic    busy
);

    logic [DEPTH-1:0] vld_pipe;
    logic [DEPTH-1:0] id_pipe;

    // Only the valid bits are cleared; a stale id is harmless without its valid.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[DEPTH-2:0], push};
        end
    end

    always_ff @(posedge clk) begin
        id_pipe <= {id_pipe[DEPTH-2:0], push_id};
    end

    assign ret_valid = vld_pipe[DEPTH-1];
    assign ret_id    = id_pipe[DEPTH-1];
    assign busy      = |vld_pipe;

endmodule

// File: rtl/sram_access_arbiter.sv
// Round-robin arbiter sharing one SRAM port between the compute engine (0) and
// the host (1). Optional grant locking is compiled in with ARB_LOCK_EN.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W          = SRAM_ADDR_W,
    parameter int DATA_W          = SRAM_DATA_W,
    parameter int RD_LATENCY      = 1,
    parameter int LOCK_MAX_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_enable,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              reads_pending
);

    arb_state_t        state;
    req_id_t           rr_ptr;
    req_id_t           owner;
    req_id_t           prio;
    req_id_t           gnt_id;
    logic              accept;
    logic              gnt_we;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_wdata;
    logic              hold;
    logic              force_rel;
    logic              enter_lock;
    logic              ret_valid;
    req_id_t           ret_id;

`ifdef ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX_CYCLES + 1);

    logic [CNT_W-1:0] lock_cnt;
    logic             owner_req;
    logic             owner_lock;
    logic             gnt_lock;

    assign owner_req  = (owner == REQ_HOST) ? req1 : req0;
    assign owner_lock = (owner == REQ_HOST) ? lock1 : lock0;
    assign gnt_lock   = (gnt_id == REQ_HOST) ? lock1 : lock0;
    // After LOCK_MAX_CYCLES locked grants the owner sits out one arbitration.
    assign force_rel  = (state == LOCKED) && (lock_cnt >= CNT_W'(LOCK_MAX_CYCLES));
    assign hold       = (state == LOCKED) && !force_rel && owner_req && owner_lock;
    assign enter_lock = gnt_lock && !force_rel;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            lock_cnt <= '0;
        end else if (accept && enter_lock) begin
            lock_cnt <= hold ? lock_cnt + 1'b1 : CNT_W'(1);
        end else begin
            lock_cnt <= '0;
        end
    end
`else
    logic unused_lock;

    assign force_rel   = 1'b0;
    assign hold        = 1'b0;
    assign enter_lock  = 1'b0;
    assign unused_lock = ^{lock0, lock1, state};
`endif

    always_comb begin
        prio = force_rel ? ~owner : rr_ptr;
        if (hold) begin
            gnt_id = owner;
        end else if (req0 && req1) begin
            gnt_id = prio;
        end else begin
            gnt_id = req1 ? REQ_HOST : REQ_ENGINE;
        end
        accept    = reset_b && (hold || req0 || req1);
        gnt0      = accept && (gnt_id == REQ_ENGINE);
        gnt1      = accept && (gnt_id == REQ_HOST);
        gnt_we    = (gnt_id == REQ_HOST) ? we1 : we0;
        gnt_addr  = (gnt_id == REQ_HOST) ? addr1 : addr0;
        gnt_wdata = (gnt_id == REQ_HOST) ? wdata1 : wdata0;
    end

    // Issue stage: the accepted access is registered onto the SRAM pins.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state             <= IDLE;
            rr_ptr            <= REQ_ENGINE;
            owner             <= REQ_ENGINE;
            mem_write_enable  <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            mem_write_enable <= accept && gnt_we;
            if (accept) begin
                rr_ptr <= ~gnt_id;
                owner  <= gnt_id;
                state  <= enter_lock ? LOCKED : GRANT;
                if (gnt_we) begin
                    mem_write_address <= gnt_addr;
                    mem_write_data    <= gnt_wdata;
                end else begin
                    mem_read_address  <= gnt_addr;
                end
            end else begin
                state <= IDLE;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH(RD_LATENCY + 1)
    ) u_rd_tag_pipe (
        .clk      (clk),
        .reset_b  (reset_b),
        .push     (accept && !gnt_we),
        .push_id  (gnt_id),
        .ret_valid(ret_valid),
        .ret_id   (ret_id),
        .busy     (reads_pending)
    );

    // Return stage: the SRAM output is steered to whichever side owns the tag.
    assign rvalid0 = ret_valid && (ret_id == REQ_ENGINE);
    assign rvalid1 = ret_valid && (ret_id == REQ_HOST);
    assign rdata   = ret_valid ? mem_read_data : '0;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter: directed stimulus, a queue-based
// reference model checked every cycle, and literal expectations per scenario.
module tb_sram_access_arbiter;

    localparam int ADDR_W   = 12;
    localparam int DATA_W   = 16;
    localparam int RD_LAT   = 3;
    localparam int LOCK_MAX = 4;

    logic              clk = 1'b0;
    logic              reset_b;
    logic              req0, req1, we0, we1, lock0, lock1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_read_address, mem_write_address;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;
    logic              mem_write_enable, reads_pending;

    always #5 clk = ~clk;

    sram_access_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(RD_LAT), .LOCK_MAX_CYCLES(LOCK_MAX)
    ) dut (
        .clk(clk), .reset_b(reset_b),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
        .mem_read_data(mem_read_data), .reads_pending(reads_pending)
    );

    function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
        return {4'h0, a} ^ 16'h5A5A;
    endfunction

    // SRAM macro: write-first, RD_LAT cycles from registered address to data.
    logic [DATA_W-1:0]       sram [0:(1<<ADDR_W)-1];
    logic [(1<<ADDR_W)-1:0]  written = '0;
    logic [DATA_W-1:0]       sram_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_write_enable) begin
            sram[mem_write_address]    <= mem_write_data;
            written[mem_write_address] <= 1'b1;
        end
        if (mem_write_enable && mem_write_address == mem_read_address)
            sram_pipe[0] <= mem_write_data;
        else
            sram_pipe[0] <= written[mem_read_address] ? sram[mem_read_address]
                                                       : init_word(mem_read_address);
        for (int k = 1; k < RD_LAT; k++) sram_pipe[k] <= sram_pipe[k-1];
    end
    assign mem_read_data = sram_pipe[RD_LAT-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int                due;
        int                id;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              rq[$];
    logic [DATA_W-1:0] mdl_mem [logic [ADDR_W-1:0]];
    int                rr = 0;
    int                run = 0;
    int                own = 0;
    logic [ADDR_W-1:0] e_mra = '0, e_mwa = '0;
    logic [DATA_W-1:0] e_mwd = '0;
    logic              e_mwe = 1'b0;

    // Observed activity, used by the scenario-level literal checks
    int                rv_cnt [2] = '{0, 0};
    int                mwe_cnt = 0;
    logic [DATA_W-1:0] last_rd [2];

    always @(negedge clk) begin
        logic [1:0]        rqv, lk;
        logic              hold, forced, g, ew, e0, e1;
        int                gid, prio;
        logic [ADDR_W-1:0] ga;
        logic [DATA_W-1:0] gd, erd;
        cyc++;
        if (rvalid0) begin rv_cnt[0]++; last_rd[0] = rdata; end
        if (rvalid1) begin rv_cnt[1]++; last_rd[1] = rdata; end
        if (mem_write_enable) mwe_cnt++;
        if (!reset_b) begin
            rr = 0; run = 0; own = 0; rq.delete();
            e_mra = '0; e_mwa = '0; e_mwd = '0; e_mwe = 1'b0;
            chk("rst_gnt", {gnt1, gnt0}, 2'b00);
            chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
            chk("rst_rdata", rdata, 0);
            chk("rst_mem_we", mem_write_enable, 0);
            chk("rst_mem_ra", mem_read_address, 0);
            chk("rst_mem_wa", mem_write_address, 0);
            chk("rst_mem_wd", mem_write_data, 0);
            chk("rst_pending", reads_pending, 0);
        end else begin
            chk("pending", reads_pending, rq.size() != 0);
            e0 = 1'b0; e1 = 1'b0; erd = '0;
            if (rq.size() != 0 && rq[0].due == cyc) begin
                if (rq[0].id == 0) e0 = 1'b1; else e1 = 1'b1;
                erd = rq[0].data;
                void'(rq.pop_front());
            end
            chk("rvalid", {rvalid1, rvalid0}, {e1, e0});
            if (e0 || e1) chk("rdata", rdata, erd);
            chk("mem_we", mem_write_enable, e_mwe);
            chk("mem_ra", mem_read_address, e_mra);
            chk("mem_wa", mem_write_address, e_mwa);
            chk("mem_wd", mem_write_data, e_mwd);

            rqv = {req1, req0};
            lk  = {lock1, lock0};
            hold = 1'b0; forced = 1'b0;
`ifdef ARB_LOCK_EN
            if (run >= LOCK_MAX) forced = 1'b1;
            else if (run > 0 && rqv[own] && lk[own]) hold = 1'b1;
`endif
            prio = forced ? 1 - own : rr;
            g = 1'b1; gid = 0;
            if (hold) gid = own;
            else if (rqv == 2'b11) gid = prio;
            else if (rqv == 2'b10) gid = 1;
            else if (rqv == 2'b01) gid = 0;
            else g = 1'b0;
            chk("gnt", {gnt1, gnt0}, g ? (gid == 1 ? 2'b10 : 2'b01) : 2'b00);

            e_mwe = 1'b0;
            if (g) begin
                rr = 1 - gid;
`ifdef ARB_LOCK_EN
                if (hold) run++;
                else if (lk[gid] && !forced) begin run = 1; own = gid; end
                else run = 0;
`endif
                ew = gid ? we1 : we0;
                ga = gid ? addr1 : addr0;
                gd = gid ? wdata1 : wdata0;
                if (ew) begin
                    mdl_mem[ga] = gd;
                    e_mwe = 1'b1; e_mwa = ga; e_mwd = gd;
                end else begin
                    e_mra = ga;
                    rq.push_back('{cyc + 1 + RD_LAT, gid,
                                   mdl_mem.exists(ga) ? mdl_mem[ga] : init_word(ga)});
                end
            end else begin
                run = 0;
            end
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic l0,
                         input logic r1, input logic w1, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1, input logic l1);
        @(posedge clk);
        #1;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    int b0, b1, bm, bt;
    logic [9:0] pat;

    initial begin
        reset_b = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0; lock0 = 0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0; lock1 = 0;
        repeat (2) idle();
        idle(); reset_b = 1'b1;

        // Reset mid-stream: read issued by the engine, reset before its return
        b0 = rv_cnt[0];
        drive(1, 0, 12'h040, '0, 0, 0, 0, '0, '0, 0);
        idle();
        drive(1, 0, 12'h050, '0, 0, 0, 0, '0, '0, 0);
        reset_b = 1'b0;
        #1;
        chk("t1_gnt_in_reset", {gnt1, gnt0}, 2'b00);
        chk("t1_mem_ra_cleared", mem_read_address, 0);
        idle();
        idle(); reset_b = 1'b1;
        repeat (RD_LAT + 3) idle();
        chk("t1_no_rvalid0", rv_cnt[0] - b0, 0);

        // Continuous contention: strict alternation from rr_ptr = 0
        b0 = rv_cnt[0]; b1 = rv_cnt[1];
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 12'h010, '0, 0, 1, 0, 12'h020, '0, 0);
            #1;
            chk("t2_gnt_alt", {gnt1, gnt0}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        repeat (RD_LAT + 2) idle();
        chk("t2_rv0_count", rv_cnt[0] - b0, 3);
        chk("t2_rv1_count", rv_cnt[1] - b1, 3);
        chk("t2_rdata0", last_rd[0], 16'h5A4A);
        chk("t2_rdata1", last_rd[1], 16'h5A7A);

        // Host alone (lock1 high but must not matter), then contention favours the engine
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, '0, '0, 0, 1, 0, 12'(12'h100 + i), '0, 1);
            #1;
            chk("t3_gnt_host", {gnt1, gnt0}, 2'b10);
        end
        drive(1, 0, 12'h300, '0, 0, 1, 0, 12'h301, '0, 0);
        #1;
        chk("t3_contend", {gnt1, gnt0}, 2'b01);
        drive(0, 0, '0, '0, 0, 1, 0, 12'h301, '0, 0);
        #1;
        chk("t3_host_next", {gnt1, gnt0}, 2'b10);
        repeat (RD_LAT + 2) idle();

        // Write then read of the same address on consecutive grants
        bm = mwe_cnt; b1 = rv_cnt[1];
        drive(1, 1, 12'h0A5, 16'hBEEF, 0, 0, 0, '0, '0, 0);
        drive(0, 0, '0, '0, 0, 1, 0, 12'h0A5, '0, 0);
        #1;
        chk("t4_write_issued", {mem_write_enable, mem_write_address}, {1'b1, 12'h0A5});
        repeat (RD_LAT + 3) idle();
        chk("t4_we_pulses", mwe_cnt - bm, 1);
        chk("t4_rv1_count", rv_cnt[1] - b1, 1);
        chk("t4_rdata_new", last_rd[1], 16'hBEEF);

        // Eight back-to-back reads, alternating owners
        bt = rv_cnt[0] + rv_cnt[1];
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1, 0, 12'(12'h200 + i), '0, 0, 0, 0, '0, '0, 0);
            else            drive(0, 0, '0, '0, 0, 1, 0, 12'(12'h200 + i), '0, 0);
        end
        for (int k = 1; k <= RD_LAT + 2; k++) begin
            idle();
            #1;
            chk("t6_pending", reads_pending, k <= RD_LAT + 1);
        end
        chk("t6_rv_total", rv_cnt[0] + rv_cnt[1] - bt, 8);

`ifdef ARB_LOCK_EN
        // Engine holds lock; forced release every LOCK_MAX locked grants
        repeat (2) idle();
        pat = 10'h210;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 12'h400, '0, 1, 1, 0, 12'h401, '0, 0);
            #1;
            chk("t5_lock_gnt", {gnt1, gnt0}, pat[i] ? 2'b10 : 2'b01);
        end
        repeat (RD_LAT + 2) idle();
`else
        pat = '0;
`endif

        repeat (3) idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
